packet_switch_dbg_avmm_arb: RTL and testbench
=============================================

# packet_switch_dbg_avmm_arb

Two-master Avalon-MM arbiter that shares one packet-switch debug-counter CSR slave, such as the RX debug counter interface, between the host CSR path (master 0) and an internal statistics poller (master 1). It grants one transaction at a time using round-robin order and keeps at most one read outstanding. It routes the slave's `readdatavalid` back to the master that issued the read. A read timeout guarantees that every accepted read gets a response, even if the slave never answers.

## Interface
Parameters:
- `ADDR_WIDTH`, 8: address width of masters and slave.
- `DATA_WIDTH`, 32: data width; byteenable width is `DATA_WIDTH/8`.
- `TIMEOUT_CYCLES`, 64: cycles to wait for `s_readdatavalid` after a read is issued; minimum 2.
- `TIMEOUT_DATA`, 'hDEADBEEF: readdata returned when a read times out.

Ports (`m*` signals are per master, index 0 = host, 1 = poller):
- `clk`  in  1  single clock for all logic.
- `rst_n`  in  1  asynchronous, active-low reset.
- `m_address`  in  [1:0][ADDR_WIDTH]  master address.
- `m_read`, `m_write`  in  [1:0]  request strobes; held until accepted.
- `m_writedata`  in  [1:0][DATA_WIDTH]  write data.
- `m_byteenable`  in  [1:0][DATA_WIDTH/8]  byte enables.
- `m_waitrequest`  out  [1:0]  request not accepted.
- `m_readdata`  out  [1:0][DATA_WIDTH]  read response data.
- `m_readdatavalid`  out  [1:0]  read response strobe.
- `s_address`  out  ADDR_WIDTH  address to slave.
- `s_read`, `s_write`  out  1  one-cycle strobes to slave.
- `s_writedata`  out  DATA_WIDTH  write data to slave.
- `s_byteenable`  out  DATA_WIDTH/8  byte enables to slave.
- `s_readdata`  in  DATA_WIDTH  slave read data.
- `s_readdatavalid`  in  1  slave read response strobe.
- `timeout_err`  out  1  one-cycle pulse when a read times out.
- `timeout_cnt`  out  16  count of timeouts since reset; saturates at 'hFFFF.

## Operation
- States: IDLE, ISSUE, WAIT_RD.
- **Request:** a master requests when `m_read | m_write`. If both strobes are set, the read takes precedence.
- **IDLE:** when any master requests, the arbiter grants one master.
  - The grant goes to the requester that was not granted last.
  - A lone requester is always granted.
  - `last_grant` resets to 1, so master 0 wins the first contention.
- **Accept:** in the grant cycle, `m_waitrequest[g]` goes low (combinational from state and request). All other `m_waitrequest` bits are 1.
  - Address, data, byteenable, op and g are captured.
  - The state moves to ISSUE.
- **ISSUE:** for one cycle, assert `s_read` or `s_write` with the captured fields.
  - After a write, go to IDLE.
  - After a read, go to WAIT_RD and clear the timeout counter.
- **WAIT_RD:** the timeout counter increments each cycle.
  - On `s_readdatavalid`: register `s_readdata` into `m_readdata[g]`, pulse `m_readdatavalid[g]` on the next cycle, and go to IDLE.
  - If the counter reaches `TIMEOUT_CYCLES - 1` with no valid: on the next cycle, pulse `m_readdatavalid[g]` with `TIMEOUT_DATA`, pulse `timeout_err`, increment `timeout_cnt` (saturating), and go to IDLE.
  - If valid and expiry occur in the same cycle, the valid wins; no timeout is recorded.
- **Stray responses:** an `s_readdatavalid` that arrives outside WAIT_RD (for example, a late response after a timeout) is discarded. It produces no master strobe.
- **Idle outputs:** `m_readdata` of the non-responding master holds its last value. `s_*` fields hold their captured values when not strobed.
- **Reset:** asserting `rst_n` low mid-transaction aborts any outstanding read. No response is ever delivered for it.

## Timing
- **Reset values:**
  - `m_waitrequest` = 2'b11.
  - `m_readdatavalid`, `s_read`, `s_write`, `timeout_err` = 0.
  - `m_readdata`, `s_address`, `s_writedata`, `s_byteenable` = 0.
  - `timeout_cnt` = 0.
  - State IDLE; `last_grant` = 1.
- **Accept:** in cycle T, in IDLE. `s_read`/`s_write` is asserted in T+1.
- **Write:** back in IDLE at T+2, which is the earliest next accept. Throughput is one write per 2 cycles.
- **Read:** if `s_readdatavalid` arrives in T+1+k (k ≥ 1), `m_readdatavalid[g]` asserts in T+2+k. The next accept is possible in T+2+k.
- **Timeout:** response delivered at T+2+`TIMEOUT_CYCLES`.
- **Holding:** a non-granted requester keeps `m_waitrequest` high and must hold its request stable. It is granted at the next IDLE, because round-robin guarantees no starvation.

## Test plan
- **Single write:** m0 writes addr 'h04, data 'h12345678, be 'hF. Required: `m_waitrequest[0]`=0 in T; `s_write`=1 in T+1 with the same fields for exactly 1 cycle; m0 can be accepted again in T+2.
- **Read round-trip:** m1 reads addr 'h08; slave returns 'hCAFE0001 with k=2. Required: `m_readdatavalid[1]`=1 and `m_readdata[1]`='hCAFE0001 at T+4; `m_readdatavalid[0]` stays 0 throughout.
- **Contention:** m0 and m1 issue continuous simultaneous reads from reset. Required: grants go m0, m1, m0, m1, …; no two reads are ever outstanding.
- **Timeout:** with `TIMEOUT_CYCLES`=8, m0 reads and the slave never responds. Required: at T+10, `m_readdatavalid[0]`=1 with 'hDEADBEEF and `timeout_err`=1; `timeout_cnt`=1. A late `s_readdatavalid` at T+12 produces no master strobe.
- **Timeout race:** `s_readdatavalid` arrives exactly on the expiry cycle. Required: the real data is returned, `timeout_err` stays 0 and `timeout_cnt` is unchanged.
- **Reset mid-read:** assert `rst_n` low while in WAIT_RD, then release. Required: all outputs take their reset values immediately; no response is delivered for the aborted read; the first contention after reset is granted to m0.

Source files
------------

// File: rtl/packet_switch_dbg_avmm_arb.sv
// Two-master Avalon-MM arbiter for a shared debug-counter CSR slave.
// Round-robin grant, one transaction in flight, read timeout with a substitute response.
module packet_switch_dbg_avmm_arb #(
  parameter int                    ADDR_WIDTH     = 8,
  parameter int                    DATA_WIDTH     = 32,
  parameter int                    TIMEOUT_CYCLES = 64,
  parameter logic [DATA_WIDTH-1:0] TIMEOUT_DATA   = 'hDEADBEEF
) (
  input  logic                                  clk,
  input  logic                                  rst_n,
  input  logic [1:0][ADDR_WIDTH-1:0]            m_address,
  input  logic [1:0]                            m_read,
  input  logic [1:0]                            m_write,
  input  logic [1:0][DATA_WIDTH-1:0]            m_writedata,
  input  logic [1:0][DATA_WIDTH/8-1:0]          m_byteenable,
  output logic [1:0]                            m_waitrequest,
  output logic [1:0][DATA_WIDTH-1:0]            m_readdata,
  output logic [1:0]                            m_readdatavalid,
  output logic [ADDR_WIDTH-1:0]                 s_address,
  output logic                                  s_read,
  output logic                                  s_write,
  output logic [DATA_WIDTH-1:0]                 s_writedata,
  output logic [DATA_WIDTH/8-1:0]               s_byteenable,
  input  logic [DATA_WIDTH-1:0]                 s_readdata,
  input  logic                                  s_readdatavalid,
  output logic                                  timeout_err,
  output logic [15:0]                           timeout_cnt
);

  localparam int CNT_W = $clog2(TIMEOUT_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT_RD} state_t;

  state_t           state;
  logic             last_grant;
  logic             cur_g;
  logic [CNT_W-1:0] wait_cnt;
  logic [1:0]       req;
  logic             accept;
  logic             gnt_idx;
  logic             gnt_rd;

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  // Grant selection: alternate under contention, a lone requester always wins.
  always_comb begin
    req           = m_read | m_write;
    accept        = (state == IDLE) && (|req);
    gnt_idx       = (req == 2'b11) ? ~last_grant : req[1];
    gnt_rd        = m_read[gnt_idx];
    m_waitrequest = 2'b11;
    if (accept)
      m_waitrequest[gnt_idx] = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state           <= IDLE;
      last_grant      <= 1'b1;
      cur_g           <= 1'b0;
      wait_cnt        <= '0;
      m_readdata      <= '0;
      m_readdatavalid <= 2'b00;
      s_address       <= '0;
      s_read          <= 1'b0;
      s_write         <= 1'b0;
      s_writedata     <= '0;
      s_byteenable    <= '0;
      timeout_err     <= 1'b0;
      timeout_cnt     <= 16'd0;
    end else begin
      s_read          <= 1'b0;
      s_write         <= 1'b0;
      m_readdatavalid <= 2'b00;
      timeout_err     <= 1'b0;
      case (state)
        IDLE: begin
          if (accept) begin
            last_grant   <= gnt_idx;
            cur_g        <= gnt_idx;
            s_address    <= m_address[gnt_idx];
            s_writedata  <= m_writedata[gnt_idx];
            s_byteenable <= m_byteenable[gnt_idx];
            s_read       <= gnt_rd;
            s_write      <= ~gnt_rd;
            state        <= ISSUE;
          end
        end
        // s_read is high exactly during ISSUE for a read, so it doubles as the captured op.
        ISSUE: begin
          if (s_read) begin
            wait_cnt <= '0;
            state    <= WAIT_RD;
          end else begin
            state    <= IDLE;
          end
        end
        WAIT_RD: begin
          if (s_readdatavalid) begin
            m_readdata[cur_g]      <= s_readdata;
            m_readdatavalid[cur_g] <= 1'b1;
            state                  <= IDLE;
          end else if (wait_cnt == CNT_LAST) begin
            m_readdata[cur_g]      <= TIMEOUT_DATA;
            m_readdatavalid[cur_g] <= 1'b1;
            timeout_err            <= 1'b1;
            timeout_cnt            <= sat_inc16(timeout_cnt);
            state                  <= IDLE;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_packet_switch_dbg_avmm_arb.sv
// Directed bench for packet_switch_dbg_avmm_arb: writes, reads, contention,
// timeout, timeout race and reset during an outstanding read.
module tb_packet_switch_dbg_avmm_arb;

  localparam int TC = 8;

  logic                 clk = 1'b0;
  logic                 rst_n = 1'b0;
  logic [1:0][7:0]      m_address = '0;
  logic [1:0]           m_read = 2'b00;
  logic [1:0]           m_write = 2'b00;
  logic [1:0][31:0]     m_writedata = '0;
  logic [1:0][3:0]      m_byteenable = '0;
  logic [1:0]           m_waitrequest;
  logic [1:0][31:0]     m_readdata;
  logic [1:0]           m_readdatavalid;
  logic [7:0]           s_address;
  logic                 s_read;
  logic                 s_write;
  logic [31:0]          s_writedata;
  logic [3:0]           s_byteenable;
  logic [31:0]          s_readdata = '0;
  logic                 s_readdatavalid = 1'b0;
  logic                 timeout_err;
  logic [15:0]          timeout_cnt;

  int n_chk = 0;
  int n_fail = 0;

  packet_switch_dbg_avmm_arb #(
    .ADDR_WIDTH(8), .DATA_WIDTH(32), .TIMEOUT_CYCLES(TC), .TIMEOUT_DATA(32'hDEADBEEF)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .m_address(m_address), .m_read(m_read), .m_write(m_write),
    .m_writedata(m_writedata), .m_byteenable(m_byteenable),
    .m_waitrequest(m_waitrequest), .m_readdata(m_readdata),
    .m_readdatavalid(m_readdatavalid),
    .s_address(s_address), .s_read(s_read), .s_write(s_write),
    .s_writedata(s_writedata), .s_byteenable(s_byteenable),
    .s_readdata(s_readdata), .s_readdatavalid(s_readdatavalid),
    .timeout_err(timeout_err), .timeout_cnt(timeout_cnt)
  );

  always #5 clk = ~clk;

  // Inputs change 1ns after the rising edge; outputs are sampled on the falling edge.
  task automatic adv();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    adv(); adv();
    @(negedge clk);
    n_chk++; if (m_waitrequest !== 2'b11) begin n_fail++; $display("FAIL rst_wait act=%b exp=11", m_waitrequest); end
    n_chk++; if ({m_readdatavalid, s_read, s_write, timeout_err} !== 5'b0) begin n_fail++; $display("FAIL rst_strobes act=%b exp=0", {m_readdatavalid, s_read, s_write, timeout_err}); end
    n_chk++; if (m_readdata !== 64'd0) begin n_fail++; $display("FAIL rst_rdata act=%h exp=0", m_readdata); end
    n_chk++; if ({s_address, s_writedata, s_byteenable} !== 44'd0) begin n_fail++; $display("FAIL rst_sfields act=%h exp=0", {s_address, s_writedata, s_byteenable}); end
    n_chk++; if (timeout_cnt !== 16'd0) begin n_fail++; $display("FAIL rst_tcnt act=%0d exp=0", timeout_cnt); end
    adv(); rst_n = 1'b1;
  endtask

  task automatic test_single_write();
    adv(); m_write = 2'b01; m_address[0] = 8'h04; m_writedata[0] = 32'h12345678; m_byteenable[0] = 4'hF;
    @(negedge clk);
    n_chk++; if (m_waitrequest !== 2'b10) begin n_fail++; $display("FAIL wr_accept act=%b exp=10", m_waitrequest); end
    adv(); m_write = 2'b00;
    @(negedge clk);
    n_chk++; if ({s_write, s_read} !== 2'b10) begin n_fail++; $display("FAIL wr_strobe act=%b exp=10", {s_write, s_read}); end
    n_chk++; if ({s_address, s_writedata, s_byteenable} !== {8'h04, 32'h12345678, 4'hF}) begin n_fail++; $display("FAIL wr_fields act=%h exp=%h", {s_address, s_writedata, s_byteenable}, {8'h04, 32'h12345678, 4'hF}); end
    adv(); m_write = 2'b01; m_address[0] = 8'h05;
    @(negedge clk);
    n_chk++; if (s_write !== 1'b0) begin n_fail++; $display("FAIL wr_one_cycle act=%b exp=0", s_write); end
    n_chk++; if (m_waitrequest !== 2'b10) begin n_fail++; $display("FAIL wr_reaccept act=%b exp=10", m_waitrequest); end
    adv(); m_write = 2'b00;
    @(negedge clk);
    n_chk++; if ({s_write, s_address} !== {1'b1, 8'h05}) begin n_fail++; $display("FAIL wr2_issue act=%h exp=%h", {s_write, s_address}, {1'b1, 8'h05}); end
    adv();
    @(negedge clk);
    n_chk++; if (s_write !== 1'b0) begin n_fail++; $display("FAIL wr2_end act=%b exp=0", s_write); end
  endtask

  task automatic test_read_roundtrip();
    adv(); m_read = 2'b10; m_address[1] = 8'h08;
    @(negedge clk);
    n_chk++; if (m_waitrequest !== 2'b01) begin n_fail++; $display("FAIL rd_accept act=%b exp=01", m_waitrequest); end
    adv(); m_read = 2'b00;
    @(negedge clk);
    n_chk++; if ({s_read, s_address} !== {1'b1, 8'h08}) begin n_fail++; $display("FAIL rd_issue act=%h exp=%h", {s_read, s_address}, {1'b1, 8'h08}); end
    n_chk++; if (m_readdatavalid !== 2'b00) begin n_fail++; $display("FAIL rd_early1 act=%b exp=00", m_readdatavalid); end
    adv();
    @(negedge clk);
    n_chk++; if (m_readdatavalid !== 2'b00) begin n_fail++; $display("FAIL rd_early2 act=%b exp=00", m_readdatavalid); end
    adv(); s_readdatavalid = 1'b1; s_readdata = 32'hCAFE0001;
    @(negedge clk);
    n_chk++; if (m_readdatavalid !== 2'b00) begin n_fail++; $display("FAIL rd_early3 act=%b exp=00", m_readdatavalid); end
    adv(); s_readdatavalid = 1'b0; s_readdata = 32'h0;
    @(negedge clk);
    n_chk++; if (m_readdatavalid !== 2'b10) begin n_fail++; $display("FAIL rd_valid act=%b exp=10", m_readdatavalid); end
    n_chk++; if (m_readdata[1] !== 32'hCAFE0001) begin n_fail++; $display("FAIL rd_data act=%h exp=cafe0001", m_readdata[1]); end
    adv();
    @(negedge clk);
    n_chk++; if (m_readdatavalid !== 2'b00) begin n_fail++; $display("FAIL rd_pulse act=%b exp=00", m_readdatavalid); end
  endtask

  task automatic test_timeout();
    adv(); m_read = 2'b01; m_address[0] = 8'h0C;
    @(negedge clk);
    n_chk++; if (m_waitrequest !== 2'b10) begin n_fail++; $display("FAIL to_accept act=%b exp=10", m_waitrequest); end
    for (int i = 1; i <= TC + 1; i++) begin
      adv(); if (i == 1) m_read = 2'b00;
      @(negedge clk);
      n_chk++; if ({m_readdatavalid, timeout_err} !== 3'b000) begin n_fail++; $display("FAIL to_early cyc=%0d act=%b exp=000", i, {m_readdatavalid, timeout_err}); end
    end
    adv();
    @(negedge clk);
    n_chk++; if (m_readdatavalid !== 2'b01) begin n_fail++; $display("FAIL to_valid act=%b exp=01", m_readdatavalid); end
    n_chk++; if (m_readdata[0] !== 32'hDEADBEEF) begin n_fail++; $display("FAIL to_data act=%h exp=deadbeef", m_readdata[0]); end
    n_chk++; if (timeout_err !== 1'b1) begin n_fail++; $display("FAIL to_err act=%b exp=1", timeout_err); end
    n_chk++; if (timeout_cnt !== 16'd1) begin n_fail++; $display("FAIL to_cnt act=%0d exp=1", timeout_cnt); end
    n_chk++; if (m_readdata[1] !== 32'hCAFE0001) begin n_fail++; $display("FAIL to_hold1 act=%h exp=cafe0001", m_readdata[1]); end
    adv();
    @(negedge clk);
    n_chk++; if ({m_readdatavalid, timeout_err} !== 3'b000) begin n_fail++; $display("FAIL to_pulse act=%b exp=000", {m_readdatavalid, timeout_err}); end
    adv(); s_readdatavalid = 1'b1; s_readdata = 32'h11111111;
    @(negedge clk);
    adv(); s_readdatavalid = 1'b0; s_readdata = 32'h0;
    @(negedge clk);
    n_chk++; if ({m_readdatavalid, timeout_err} !== 3'b000) begin n_fail++; $display("FAIL to_stray act=%b exp=000", {m_readdatavalid, timeout_err}); end
    n_chk++; if (m_readdata[0] !== 32'hDEADBEEF) begin n_fail++; $display("FAIL to_stray_data act=%h exp=deadbeef", m_readdata[0]); end
  endtask

  task automatic test_timeout_race();
    adv(); m_read = 2'b01; m_address[0] = 8'h0D;
    @(negedge clk);
    n_chk++; if (m_waitrequest !== 2'b10) begin n_fail++; $display("FAIL race_accept act=%b exp=10", m_waitrequest); end
    for (int i = 1; i <= TC; i++) begin
      adv(); if (i == 1) m_read = 2'b00;
      @(negedge clk);
      n_chk++; if (m_readdatavalid !== 2'b00) begin n_fail++; $display("FAIL race_early cyc=%0d act=%b exp=00", i, m_readdatavalid); end
    end
    adv(); s_readdatavalid = 1'b1; s_readdata = 32'hABCD0002;
    @(negedge clk);
    n_chk++; if (m_readdatavalid !== 2'b00) begin n_fail++; $display("FAIL race_expiry act=%b exp=00", m_readdatavalid); end
    adv(); s_readdatavalid = 1'b0; s_readdata = 32'h0;
    @(negedge clk);
    n_chk++; if (m_readdatavalid !== 2'b01) begin n_fail++; $display("FAIL race_valid act=%b exp=01", m_readdatavalid); end
    n_chk++; if (m_readdata[0] !== 32'hABCD0002) begin n_fail++; $display("FAIL race_data act=%h exp=abcd0002", m_readdata[0]); end
    n_chk++; if (timeout_err !== 1'b0) begin n_fail++; $display("FAIL race_err act=%b exp=0", timeout_err); end
    n_chk++; if (timeout_cnt !== 16'd1) begin n_fail++; $display("FAIL race_cnt act=%0d exp=1", timeout_cnt); end
  endtask

  task automatic test_contention();
    adv(); rst_n = 1'b0;
    adv(); rst_n = 1'b1; m_read = 2'b11; m_address[0] = 8'h10; m_address[1] = 8'h20;
    @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      int g;
      g = i % 2;
      n_chk++; if (m_waitrequest !== ((g == 1) ? 2'b01 : 2'b10)) begin n_fail++; $display("FAIL cont_grant n=%0d act=%b exp_master=%0d", i, m_waitrequest, g); end
      adv();
      @(negedge clk);
      n_chk++; if ({s_read, s_address} !== {1'b1, ((g == 1) ? 8'h20 : 8'h10)}) begin n_fail++; $display("FAIL cont_issue n=%0d act=%h", i, {s_read, s_address}); end
      n_chk++; if (m_waitrequest !== 2'b11) begin n_fail++; $display("FAIL cont_busy1 n=%0d act=%b exp=11", i, m_waitrequest); end
      adv(); s_readdatavalid = 1'b1; s_readdata = 32'hA0000000 + i;
      @(negedge clk);
      n_chk++; if (m_waitrequest !== 2'b11) begin n_fail++; $display("FAIL cont_busy2 n=%0d act=%b exp=11", i, m_waitrequest); end
      adv(); s_readdatavalid = 1'b0; s_readdata = 32'h0; if (i == 3) m_read = 2'b00;
      @(negedge clk);
      n_chk++; if (m_readdatavalid !== ((g == 1) ? 2'b10 : 2'b01)) begin n_fail++; $display("FAIL cont_valid n=%0d act=%b", i, m_readdatavalid); end
      n_chk++; if (m_readdata[g] !== 32'hA0000000 + i) begin n_fail++; $display("FAIL cont_data n=%0d act=%h exp=%h", i, m_readdata[g], 32'hA0000000 + i); end
    end
  endtask

  task automatic test_reset_mid_read();
    adv(); m_read = 2'b01; m_address[0] = 8'h30;
    @(negedge clk);
    n_chk++; if (m_waitrequest !== 2'b10) begin n_fail++; $display("FAIL mid_accept act=%b exp=10", m_waitrequest); end
    adv(); m_read = 2'b00;
    adv();
    adv(); rst_n = 1'b0;
    #1;
    n_chk++; if ({s_address, s_read, m_readdata} !== 73'd0) begin n_fail++; $display("FAIL mid_rst_vals act=%h exp=0", {s_address, s_read, m_readdata}); end
    n_chk++; if (m_waitrequest !== 2'b11) begin n_fail++; $display("FAIL mid_rst_wait act=%b exp=11", m_waitrequest); end
    adv();
    adv(); rst_n = 1'b1;
    for (int i = 0; i < TC + 4; i++) begin
      adv(); s_readdatavalid = (i == 2); s_readdata = 32'h55555555;
      @(negedge clk);
      n_chk++; if ({m_readdatavalid, timeout_err} !== 3'b000) begin n_fail++; $display("FAIL mid_no_resp cyc=%0d act=%b exp=000", i, {m_readdatavalid, timeout_err}); end
    end
    adv(); s_readdatavalid = 1'b0; m_read = 2'b11; m_address[0] = 8'h40; m_address[1] = 8'h41;
    @(negedge clk);
    n_chk++; if (m_waitrequest !== 2'b10) begin n_fail++; $display("FAIL mid_first_grant act=%b exp=10", m_waitrequest); end
    adv(); m_read = 2'b00;
    @(negedge clk);
    n_chk++; if ({s_read, s_address} !== {1'b1, 8'h40}) begin n_fail++; $display("FAIL mid_issue act=%h exp=%h", {s_read, s_address}, {1'b1, 8'h40}); end
  endtask

  initial begin
    test_reset();
    test_single_write();
    test_read_roundtrip();
    test_timeout();
    test_timeout_race();
    test_contention();
    test_reset_mid_read();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
